dmux_stream: RTL and testbench

DMUX_STREAM -- requirements
Module: dmux_stream

---
 rtl/dmux_stream.sv | 113 +++++++++++
 tb/tb_dmux_stream.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmux_stream.sv
// One-deep stream demultiplexer: routes each input word to port A or B by select.
// Optional per-port transfer counters are built when DMUX_STREAM_COUNT_EN is defined.
module dmux_stream #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             select,
  output logic             outA_valid,
  input  logic             outA_ready,
  output logic [WIDTH-1:0] outA_data,
  output logic             outB_valid,
  input  logic             outB_ready,
  output logic [WIDTH-1:0] outB_data,
  output logic [15:0]      countA,
  output logic [15:0]      countB
);

  localparam int unsigned CountWidth = 16;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL_A = 2'd1,
    FULL_B = 2'd2
  } state_t;

  state_t           state;
  state_t           nextState;
  logic [WIDTH-1:0] heldWord;
  logic             inHandshake;

  // State and held word; the word only moves on an accepted input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      heldWord <= '0;
    end else begin
      state <= nextState;
      if (inHandshake) begin
        heldWord <= in_data;
      end
    end
  end

  // Outputs decode from the registered state only; in_ready also looks at the held port's ready.
  always_comb begin
    nextState   = state;
    in_ready    = 1'b0;
    inHandshake = 1'b0;
    outA_valid  = 1'b0;
    outB_valid  = 1'b0;
    outA_data   = '0;
    outB_data   = '0;

    case (state)
      EMPTY: begin
        in_ready = !reset;
      end
      FULL_A: begin
        outA_valid = 1'b1;
        outA_data  = heldWord;
        in_ready   = !reset && outA_ready;
      end
      FULL_B: begin
        outB_valid = 1'b1;
        outB_data  = heldWord;
        in_ready   = !reset && outB_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase

    inHandshake = in_valid && in_ready;

    // A held word leaves whenever in_ready is high, so an input handshake implies it drained.
    if (inHandshake) begin
      nextState = select ? FULL_B : FULL_A;
    end else if ((outA_valid && outA_ready) || (outB_valid && outB_ready)) begin
      nextState = EMPTY;
    end
  end

`ifdef DMUX_STREAM_COUNT_EN
  logic [CountWidth-1:0] countAReg;
  logic [CountWidth-1:0] countBReg;

  // Completed output transfers per port, free-running with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      countAReg <= '0;
      countBReg <= '0;
    end else begin
      if (outA_valid && outA_ready) begin
        countAReg <= countAReg + CountWidth'(1);
      end
      if (outB_valid && outB_ready) begin
        countBReg <= countBReg + CountWidth'(1);
      end
    end
  end

  assign countA = countAReg;
  assign countB = countBReg;
`else
  assign countA = CountWidth'(0);
  assign countB = CountWidth'(0);
`endif

endmodule

// File: tb/tb_dmux_stream.sv
// Directed self-checking bench for dmux_stream; counter expectations follow DMUX_STREAM_COUNT_EN.
module tb_dmux_stream;

  localparam int unsigned WIDTH = 16;
`ifdef DMUX_STREAM_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             select;
  logic             outA_valid;
  logic             outA_ready;
  logic [WIDTH-1:0] outA_data;
  logic             outB_valid;
  logic             outB_ready;
  logic [WIDTH-1:0] outB_data;
  logic [15:0]      countA;
  logic [15:0]      countB;

  int checks;
  int failures;

  dmux_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .select    (select),
    .outA_valid(outA_valid),
    .outA_ready(outA_ready),
    .outA_data (outA_data),
    .outB_valid(outB_valid),
    .outB_ready(outB_ready),
    .outB_data (outB_data),
    .countA    (countA),
    .countB    (countB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expCount(input int n);
    return CountEn ? 32'(n) : 32'd0;
  endfunction

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    select     = 1'b0;
    outA_ready = 1'b0;
    outB_ready = 1'b0;

    // Reset state
    #1;
    checkValue("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    checkValue("rst_in_ready_hold", 32'(in_ready), 32'd0);
    checkValue("rst_outA_valid", 32'(outA_valid), 32'd0);
    checkValue("rst_outB_valid", 32'(outB_valid), 32'd0);
    checkValue("rst_outA_data", 32'(outA_data), 32'd0);
    checkValue("rst_outB_data", 32'(outB_data), 32'd0);
    checkValue("rst_countA", 32'(countA), 32'd0);
    checkValue("rst_countB", 32'(countB), 32'd0);
    reset = 1'b0;
    #1;
    checkValue("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Load 1234 to A with A stalled; must hold for 5 cycles while inputs wiggle
    in_valid = 1'b1; select = 1'b0; in_data = 16'h1234;
    step();
    for (int i = 0; i < 5; i++) begin
      in_data = 16'h5500 + 16'(i);
      select  = i[0];
      #1;
      checkValue("hold_outA_valid", 32'(outA_valid), 32'd1);
      checkValue("hold_outA_data", 32'(outA_data), 32'h1234);
      checkValue("hold_outB_valid", 32'(outB_valid), 32'd0);
      checkValue("hold_outB_data", 32'(outB_data), 32'd0);
      checkValue("hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    outA_ready = 1'b1;
    #1;
    checkValue("drainA_in_ready", 32'(in_ready), 32'd1);
    step();
    checkValue("drainA_outA_valid", 32'(outA_valid), 32'd0);
    checkValue("drainA_countA", 32'(countA), expCount(1));

    // Streaming 1..8 alternating A,B, starting from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    outA_ready = 1'b1; outB_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      select   = (i % 2 == 0);
      #1;
      checkValue("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      if (i % 2 == 1) begin
        checkValue("stream_outA_valid", 32'(outA_valid), 32'd1);
        checkValue("stream_outA_data", 32'(outA_data), 32'(i));
        checkValue("stream_outB_valid", 32'(outB_valid), 32'd0);
      end else begin
        checkValue("stream_outB_valid", 32'(outB_valid), 32'd1);
        checkValue("stream_outB_data", 32'(outB_data), 32'(i));
        checkValue("stream_outA_valid", 32'(outA_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    step();
    checkValue("stream_empty_A", 32'(outA_valid), 32'd0);
    checkValue("stream_empty_B", 32'(outB_valid), 32'd0);
    checkValue("stream_countA", 32'(countA), expCount(4));
    checkValue("stream_countB", 32'(countB), expCount(4));

    // B held with B stalled; A's ready must not open in_ready
    outB_ready = 1'b0; outA_ready = 1'b1;
    in_valid = 1'b1; select = 1'b1; in_data = 16'hABCD;
    step();
    in_data = 16'h7777; select = 1'b0;
    for (int i = 0; i < 3; i++) begin
      outA_ready = i[0];
      #1;
      checkValue("stallB_in_ready", 32'(in_ready), 32'd0);
      checkValue("stallB_outB_valid", 32'(outB_valid), 32'd1);
      checkValue("stallB_outB_data", 32'(outB_data), 32'hABCD);
      checkValue("stallB_outA_valid", 32'(outA_valid), 32'd0);
      step();
    end
    in_valid = 1'b0; outB_ready = 1'b1;
    step();
    checkValue("drainB_outB_valid", 32'(outB_valid), 32'd0);
    checkValue("drainB_countB", 32'(countB), expCount(5));

    // Reset while A holds BEEF
    outA_ready = 1'b0;
    in_valid = 1'b1; select = 1'b0; in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    #1;
    checkValue("beef_outA_data", 32'(outA_data), 32'hBEEF);
    reset = 1'b1;
    outA_ready = 1'b1;
    in_valid = 1'b1;
    #1;
    checkValue("beef_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    checkValue("beef_rst_outA_valid", 32'(outA_valid), 32'd0);
    checkValue("beef_rst_outA_data", 32'(outA_data), 32'd0);
    checkValue("beef_rst_countA", 32'(countA), 32'd0);
    checkValue("beef_rst_countB", 32'(countB), 32'd0);
    checkValue("beef_rst_in_ready2", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkValue("beef_post_in_ready", 32'(in_ready), 32'd1);

    // Counter wrap: one B transfer, then 65535 A transfers, then one more
    outA_ready = 1'b1; outB_ready = 1'b1;
    in_valid = 1'b1; select = 1'b1; in_data = 16'h00B0;
    step();
    in_valid = 1'b0;
    step();
    checkValue("wrap_pre_countB", 32'(countB), expCount(1));
    in_valid = 1'b1; select = 1'b0; in_data = 16'hA000;
    for (int i = 0; i < 65535; i++) begin
      step();
    end
    in_valid = 1'b0;
    step();
    checkValue("wrap_countA_ffff", 32'(countA), CountEn ? 32'hFFFF : 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checkValue("wrap_countA_zero", 32'(countA), 32'd0);
    checkValue("wrap_countB_same", 32'(countB), expCount(1));
    checkValue("wrap_outA_valid", 32'(outA_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
